// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment table and default parameters for seg7_scan
package seg7_pkg;

    // Scan FSM: all digits dark (dead time) or one digit driven
    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    localparam int NDIG_DEF      = 4;
    localparam int PRESCALE_DEF  = 1000;
    localparam int BLANK_CYC_DEF = 8;

    // Hex 0..F to segments, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational 4-bit hex to 7-segment decoder
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 7-segment scanner with dead-time blanking; SEG7_LZB_EN enables leading-zero blanking
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NDIG      = NDIG_DEF,
    parameter int PRESCALE  = PRESCALE_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic              clk,
    input  logic              res,
    input  logic              load,
    input  logic [4*NDIG-1:0] din,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   dig,
    output logic              frame
);

    localparam int IW   = $clog2(NDIG);
    localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     nidx;
    logic [CW-1:0]     cnt;
    logic [4*NDIG-1:0] val;
    logic [3:0]        nib;
    logic [6:0]        dec;
    logic [6:0]        seg_next;

    // Digit that the next BLANK->ON transition will light
    assign nidx = (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;

    // Pick the nibble of the upcoming digit from the value register
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (nidx == IW'(i)) begin
                nib = val[i*4 +: 4];
            end
        end
    end

    hex_to_seg7 u_dec (
        .hex (nib),
        .seg (dec)
    );

`ifdef SEG7_LZB_EN
    logic upper_zero;

    // Upcoming digit and every more-significant digit are all zero
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (IW'(i) >= nidx && val[i*4 +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows "0"
    assign seg_next = (nidx != '0 && upper_zero) ? 7'h00 : dec;
`else
    assign seg_next = dec;
`endif

    // Value register, written only by load
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            val <= '0;
        end else if (load) begin
            val <= din;
        end
    end

    // Scan FSM: dead time, then drive one digit for PRESCALE cycles
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= BLANK;
            idx   <= IW'(NDIG - 1);
            cnt   <= '0;
            seg   <= 7'h00;
            dig   <= '0;
            frame <= 1'b0;
        end else begin
            frame <= 1'b0;
            case (state)
                BLANK: begin
                    if (cnt == CW'(BLANK_CYC - 1)) begin
                        state <= ON;
                        cnt   <= '0;
                        idx   <= nidx;
                        dig   <= NDIG'(1) << nidx;
                        seg   <= seg_next;
                        frame <= (nidx == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (cnt == CW'(PRESCALE - 1)) begin
                        state <= BLANK;
                        cnt   <= '0;
                        dig   <= '0;
                        seg   <= 7'h00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                    dig   <= '0;
                    seg   <= 7'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan (NDIG=4, PRESCALE=4, BLANK_CYC=2)
module tb_seg7_scan;

    logic        clk;
    logic        res;
    logic        load;
    logic [15:0] din;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        frame;

    int checks = 0;
    int errors = 0;

    seg7_scan #(
        .NDIG      (4),
        .PRESCALE  (4),
        .BLANK_CYC (2)
    ) dut (
        .clk   (clk),
        .res   (res),
        .load  (load),
        .din   (din),
        .seg   (seg),
        .dig   (dig),
        .frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until frame is seen, bounded to avoid hanging
    task automatic wait_frame();
        int n;
        n = 0;
        tick();
        while (frame !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (frame !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame: frame=%b after %0d cycles, required 1", frame, n);
        end
    endtask

    task automatic test_reset();
        res = 1'b0; load = 1'b0; din = 16'h0000;
        ticks(3);
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL rst_seg: got %h want 00", seg); end
        checks++; if (dig !== 4'b0000) begin errors++; $display("FAIL rst_dig: got %b want 0000", dig); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL rst_frame: got %b want 0", frame); end
        res = 1'b1;
        tick();
        checks++; if (dig !== 4'b0000) begin errors++; $display("FAIL blank1_dig: got %b want 0000", dig); end
        tick();
        checks++; if (dig !== 4'b0001) begin errors++; $display("FAIL first_on_dig: got %b want 0001", dig); end
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL first_on_seg: got %h want 3f", seg); end
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL first_frame: got %b want 1", frame); end
        tick();
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL frame_width: got %b want 0", frame); end
        ticks(2);
        checks++; if (dig !== 4'b0001) begin errors++; $display("FAIL on_hold: got %b want 0001", dig); end
        tick();
        checks++; if (dig !== 4'b0000) begin errors++; $display("FAIL on_end: got %b want 0000", dig); end
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL on_end_seg: got %h want 00", seg); end
        tick();
        checks++; if (dig !== 4'b0000) begin errors++; $display("FAIL blank2: got %b want 0000", dig); end
        tick();
        checks++; if (dig !== 4'b0010) begin errors++; $display("FAIL dig1_on: got %b want 0010", dig); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL dig1_frame: got %b want 0", frame); end
    endtask

    task automatic test_values();
        logic [3:0] exp_dig [4];
        logic [6:0] exp_seg [4];
        exp_dig = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_seg = '{7'h71, 7'h77, 7'h5B, 7'h06};
        load = 1'b1; din = 16'h12AF;
        tick();
        load = 1'b0;
        wait_frame();
        for (int d = 0; d < 4; d++) begin
            checks++; if (dig !== exp_dig[d]) begin errors++; $display("FAIL val_dig%0d: got %b want %b", d, dig, exp_dig[d]); end
            checks++; if (seg !== exp_seg[d]) begin errors++; $display("FAIL val_seg%0d: got %h want %h", d, seg, exp_seg[d]); end
            ticks(6);
        end
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL frame_period: got %b want 1", frame); end
        checks++; if (seg !== 7'h71) begin errors++; $display("FAIL frame2_seg: got %h want 71", seg); end
    endtask

    task automatic test_mid_load();
        ticks(6);
        checks++; if (dig !== 4'b0010) begin errors++; $display("FAIL mid_dig1: got %b want 0010", dig); end
        tick();
        load = 1'b1; din = 16'h0000;
        tick();
        load = 1'b0;
        checks++; if (seg !== 7'h77) begin errors++; $display("FAIL mid_keep1: got %h want 77", seg); end
        tick();
        checks++; if (seg !== 7'h77) begin errors++; $display("FAIL mid_keep2: got %h want 77", seg); end
        tick();
        checks++; if (dig !== 4'b0000) begin errors++; $display("FAIL mid_end: got %b want 0000", dig); end
        ticks(2);
        checks++; if (dig !== 4'b0100) begin errors++; $display("FAIL mid_dig2: got %b want 0100", dig); end
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL mid_dig2_seg: got %h want 3f", seg); end
    endtask

    task automatic test_async_reset();
        load = 1'b1; din = 16'h8888;
        tick();
        load = 1'b0;
        #2 res = 1'b0;
        #1;
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL async_seg: got %h want 00", seg); end
        checks++; if (dig !== 4'b0000) begin errors++; $display("FAIL async_dig: got %b want 0000", dig); end
        tick();
        res = 1'b1;
        ticks(2);
        checks++; if (dig !== 4'b0001) begin errors++; $display("FAIL rerst_dig: got %b want 0001", dig); end
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL rerst_seg: got %h want 3f", seg); end
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL rerst_frame: got %b want 1", frame); end
    endtask

    task automatic test_lzb();
        logic [3:0] exp_dig [4];
        logic [6:0] exp_seg [4];
        exp_dig = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef SEG7_LZB_EN
        exp_seg = '{7'h3F, 7'h6D, 7'h00, 7'h00};
`else
        exp_seg = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
`endif
        load = 1'b1; din = 16'h0050;
        tick();
        load = 1'b0;
        wait_frame();
        for (int d = 0; d < 4; d++) begin
            checks++; if (dig !== exp_dig[d]) begin errors++; $display("FAIL lzb_dig%0d: got %b want %b", d, dig, exp_dig[d]); end
            checks++; if (seg !== exp_seg[d]) begin errors++; $display("FAIL lzb_seg%0d: got %h want %h", d, seg, exp_seg[d]); end
            if (d < 3) ticks(6);
        end
    endtask

    task automatic test_load_on_edge();
        ticks(5);
        load = 1'b1; din = 16'h000A;
        tick();
        load = 1'b0;
        checks++; if (dig !== 4'b0001) begin errors++; $display("FAIL edge_dig: got %b want 0001", dig); end
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL edge_old: got %h want 3f", seg); end
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL edge_frame: got %b want 1", frame); end
        ticks(24);
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL edge_frame2: got %b want 1", frame); end
        checks++; if (seg !== 7'h77) begin errors++; $display("FAIL edge_new: got %h want 77", seg); end
    endtask

    initial begin
        test_reset();
        test_values();
        test_mid_load();
        test_async_reset();
        test_lzb();
        test_load_on_edge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
